ro_mem_read_arbiter: RTL and testbench
======================================

// Module: ro_mem_read_arbiter
// PURPOSE
//  Shares one AXI-style read-address/read-data port between N_PORTS read-only task stages.
//  Round-robin arbitration of AR requests into a one-entry registered slot.
//  Per-port outstanding-read credits.
//  R beats are routed back by the stage field of rid: port = rid[ID_WIDTH-1:8].
//  Sits between the read-only pipeline stages of a tile and the tile's memory/cache read port.
// PARAMETERS
//  N_PORTS          2    number of requesting stages; port k owns arid[ID_WIDTH-1:8]==k
//  ID_WIDTH         16   width of arid/rid (id_t); low 8 bits are the per-stage tag
//  MAX_OUTSTANDING  32   max in-flight reads per port; matches 5-bit stage arid free list
// PORTS
//  clk          in   1              clock
//  rstn         in   1              synchronous active-low reset
//  s_arvalid    in   N_PORTS        per-port AR valid
//  s_arready    out  N_PORTS        per-port AR ready; one-hot or zero
//  s_araddr     in   N_PORTS*32     per-port byte address
//  s_arid       in   N_PORTS*ID_W   per-port id
//  m_arvalid    out  1              shared AR valid
//  m_arready    in   1              shared AR ready
//  m_araddr     out  32             shared AR address
//  m_arid       out  ID_WIDTH       shared AR id, forwarded unchanged
//  m_rvalid     in   1              shared R valid
//  m_rready     out  1              shared R ready
//  m_rid        in   ID_WIDTH       shared R id
//  m_rdata      in   512            shared R data (one cache line)
//  s_rvalid     out  N_PORTS        per-port R valid
//  s_rready     in   N_PORTS        per-port R ready
//  s_rid        out  ID_WIDTH       m_rid broadcast to all ports
//  s_rdata      out  512            m_rdata broadcast to all ports
//  idle         out  1              slot empty and all credit counters zero
//  err          out  2              sticky: [0] bad arid stage field, [1] bad rid stage field
// BEHAVIOUR
//  Reset: slot empty, m_arvalid=0, s_arready=0, rr_ptr=0, all counters=0, err=0, idle=1.
//  eligible[k] = s_arvalid[k] & (cnt[k] < MAX_OUTSTANDING).
//  slot_free   = !m_arvalid | m_arready.
//  Grant: when slot_free, grant the first eligible port at or after rr_ptr (cyclic).
//   s_arready[grant]=1. The s_arready combinational path depends on s_arvalid and m_arready only.
//  On grant: slot <= {s_araddr, s_arid} of winner; m_arvalid <= 1; rr_ptr <= winner+1 mod N_PORTS.
//   Latency: s_ar handshake in cycle t gives m_arvalid in t+1.
//   Back-to-back grants are allowed while m_arready stays high (1 request/cycle throughput).
//  No grant and m_arvalid & m_arready: m_arvalid <= 0.
//  Slot contents must hold stable while m_arvalid & !m_arready.
//  Granted s_arid[ID_WIDTH-1:8] != winner index: forward the request anyway and set err[0].
//  R routing: p = m_rid[ID_WIDTH-1:8].
//   s_rvalid[k] = m_rvalid & (p==k).
//   m_rready = s_rready[p] if p < N_PORTS; otherwise m_rready=1, beat dropped, err[1] set.
//   Data and id are combinational pass-through; no R buffering.
//  Credits: cnt[k] += 1 on s_ar handshake of k; cnt[k] -= 1 on R handshake of k.
//   Both in the same cycle: cnt[k] unchanged.
//   Counter width is $clog2(MAX_OUTSTANDING+1); it never exceeds MAX_OUTSTANDING.
//   An R handshake with cnt==0 is a protocol violation and is asserted in simulation.
//  idle = !m_arvalid & (all cnt==0). Registered state only, no dependence on inputs.
//  Reset asserted mid-operation: slot and counters clear next edge; in-flight R beats after reset
//   are routed normally, and their credit decrement saturates at 0.
// TESTING
//  1 Reset: rstn=0 for 2 cycles -> m_arvalid=0, s_arready=0, idle=1, err=0.
//  2 Single read: port0 arid=0x0003, addr=0x100, m_arready=1.
//    -> m_arvalid in next cycle, m_araddr=0x100, m_arid=0x0003, cnt0=1.
//    -> R with rid=0x0003 -> s_rvalid=01, cnt0=0, idle=1.
//  3 Fairness: N_PORTS=2, both ports hold arvalid for 8 cycles, m_arready=1.
//    -> grants alternate 0,1,0,1...; each port gets 4.
//  4 Backpressure: m_arready=0 for 5 cycles with a slot loaded.
//    -> m_araddr/m_arid stable, s_arready=0, no grant lost.
//  5 Credits: port1 issues 32 reads, no R returned -> 33rd is blocked while port0 is still granted.
//    -> one R beat rid=0x01xx returns -> port1 is granted next cycle.
//  6 Errors: R beat rid=0x05xx with N_PORTS=2 -> m_rready=1, s_rvalid=0, err[1]=1.
//    -> port0 request with arid=0x0107 -> forwarded, err[0]=1.

Source files
------------

// File: rtl/ro_mem_read_arbiter.sv
// Round-robin AR arbiter with per-port read credits and a one-entry
// registered request slot; R beats return by the stage field of rid.
module ro_mem_read_arbiter #(
    parameter int N_PORTS         = 2,
    parameter int ID_WIDTH        = 16,
    parameter int MAX_OUTSTANDING = 32
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [N_PORTS-1:0]            s_arvalid,
    output logic [N_PORTS-1:0]            s_arready,
    input  logic [N_PORTS*32-1:0]         s_araddr,
    input  logic [N_PORTS*ID_WIDTH-1:0]   s_arid,
    output logic                          m_arvalid,
    input  logic                          m_arready,
    output logic [31:0]                   m_araddr,
    output logic [ID_WIDTH-1:0]           m_arid,
    input  logic                          m_rvalid,
    output logic                          m_rready,
    input  logic [ID_WIDTH-1:0]           m_rid,
    input  logic [511:0]                  m_rdata,
    output logic [N_PORTS-1:0]            s_rvalid,
    input  logic [N_PORTS-1:0]            s_rready,
    output logic [ID_WIDTH-1:0]           s_rid,
    output logic [511:0]                  s_rdata,
    output logic                          idle,
    output logic [1:0]                    err
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int SW = ID_WIDTH - 8;

    logic                r_arvalid;
    logic [31:0]         r_araddr;
    logic [ID_WIDTH-1:0] r_arid;
    logic [PW-1:0]       r_rr_ptr;
    logic [CW-1:0]       r_cnt [N_PORTS];
    logic [1:0]          r_err;

    logic [N_PORTS-1:0]  w_elig;
    logic [N_PORTS-1:0]  w_gnt;
    logic [N_PORTS-1:0]  w_rsel;
    logic [N_PORTS-1:0]  w_rhs;
    logic [PW-1:0]       w_gnt_idx;
    logic [PW-1:0]       w_rr_nxt;
    logic                w_gnt_vld;
    logic                w_slot_free;
    logic                w_take;
    logic                w_cnt_nz;
    logic                w_bad_arid;
    logic                w_rport_ok;
    logic [SW-1:0]       w_rport;
    logic [31:0]         w_win_addr;
    logic [ID_WIDTH-1:0] w_win_id;

    assign w_slot_free = !r_arvalid || m_arready;

    // Scan starts at the round-robin pointer and wraps once around all ports.
    always_comb begin
        int j;
        j         = 0;
        w_gnt     = '0;
        w_gnt_idx = '0;
        w_gnt_vld = 1'b0;
        w_cnt_nz  = 1'b0;
        for (int k = 0; k < N_PORTS; k++) begin
            w_elig[k] = s_arvalid[k] && (r_cnt[k] < CW'(MAX_OUTSTANDING));
            w_cnt_nz  = w_cnt_nz || (r_cnt[k] != '0);
        end
        for (int i = 0; i < N_PORTS; i++) begin
            j = int'(r_rr_ptr) + i;
            if (j >= N_PORTS) j = j - N_PORTS;
            if (!w_gnt_vld && w_elig[j]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = PW'(j);
            end
        end
        if (w_slot_free && w_gnt_vld) w_gnt[w_gnt_idx] = 1'b1;
    end

    assign w_take     = w_slot_free && w_gnt_vld;
    assign s_arready  = w_gnt;
    assign w_win_addr = s_araddr[w_gnt_idx*32 +: 32];
    assign w_win_id   = s_arid[w_gnt_idx*ID_WIDTH +: ID_WIDTH];
    assign w_bad_arid = w_win_id[ID_WIDTH-1:8] != SW'(w_gnt_idx);
    assign w_rr_nxt   = (w_gnt_idx == PW'(N_PORTS - 1)) ? '0 : w_gnt_idx + 1'b1;

    assign w_rport    = m_rid[ID_WIDTH-1:8];
    assign w_rport_ok = w_rport < SW'(N_PORTS);

    always_comb begin
        s_rvalid = '0;
        w_rsel   = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            if (w_rport == SW'(k)) begin
                s_rvalid[k] = m_rvalid;
                w_rsel[k]   = 1'b1;
            end
        end
        m_rready = w_rport_ok ? |(s_rready & w_rsel) : 1'b1;
        w_rhs    = w_rsel & {N_PORTS{m_rvalid && m_rready}};
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_arvalid <= 1'b0;
            r_araddr  <= '0;
            r_arid    <= '0;
            r_rr_ptr  <= '0;
            r_err     <= '0;
            for (int k = 0; k < N_PORTS; k++) r_cnt[k] <= '0;
        end else begin
            if (w_take) begin
                r_arvalid <= 1'b1;
                r_araddr  <= w_win_addr;
                r_arid    <= w_win_id;
                r_rr_ptr  <= w_rr_nxt;
            end else if (r_arvalid && m_arready) begin
                r_arvalid <= 1'b0;
            end
            if (w_take && w_bad_arid) r_err[0] <= 1'b1;
            if (m_rvalid && !w_rport_ok) r_err[1] <= 1'b1;
            // Decrement saturates so beats in flight across a reset are harmless.
            for (int k = 0; k < N_PORTS; k++) begin
                if (w_gnt[k] && !w_rhs[k])
                    r_cnt[k] <= r_cnt[k] + 1'b1;
                else if (!w_gnt[k] && w_rhs[k] && r_cnt[k] != '0)
                    r_cnt[k] <= r_cnt[k] - 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < N_PORTS; k++)
            if (rstn && w_rhs[k]) assert (r_cnt[k] != '0);
    end

    assign m_arvalid = r_arvalid;
    assign m_araddr  = r_araddr;
    assign m_arid    = r_arid;
    assign s_rid     = m_rid;
    assign s_rdata   = m_rdata;
    assign idle      = !r_arvalid && !w_cnt_nz;
    assign err       = r_err;

endmodule

// File: tb/tb_ro_mem_read_arbiter.sv
// Directed bench for ro_mem_read_arbiter: reset, single read, fairness,
// backpressure, credit exhaustion, error flags and mid-operation reset.
module tb_ro_mem_read_arbiter;
    logic         clk = 1'b0;
    logic         rstn;
    logic [1:0]   s_arvalid;
    logic [1:0]   s_arready;
    logic [63:0]  s_araddr;
    logic [31:0]  s_arid;
    logic         m_arvalid;
    logic         m_arready;
    logic [31:0]  m_araddr;
    logic [15:0]  m_arid;
    logic         m_rvalid;
    logic         m_rready;
    logic [15:0]  m_rid;
    logic [511:0] m_rdata;
    logic [1:0]   s_rvalid;
    logic [1:0]   s_rready;
    logic [15:0]  s_rid;
    logic [511:0] s_rdata;
    logic         idle;
    logic [1:0]   err;

    int n_cmp = 0;
    int n_bad = 0;
    int g0, g1;

    always #5 clk = ~clk;

    ro_mem_read_arbiter #(
        .N_PORTS(2), .ID_WIDTH(16), .MAX_OUTSTANDING(32)
    ) dut (
        .clk(clk), .rstn(rstn),
        .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_araddr(s_araddr), .s_arid(s_arid),
        .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_araddr(m_araddr), .m_arid(m_arid),
        .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_rid(m_rid), .m_rdata(m_rdata),
        .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_rid(s_rid), .s_rdata(s_rdata),
        .idle(idle), .err(err)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rbeat(input logic [15:0] rid);
        m_rvalid = 1'b1;
        m_rid    = rid;
        m_rdata  = {496'h0, rid};
        s_rready = 2'b11;
        tick();
        m_rvalid = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; s_arvalid = '0; s_araddr = '0; s_arid = '0;
        m_arready = 1'b0; m_rvalid = 1'b0; m_rid = '0; m_rdata = '0;
        s_rready = '0;
        tick(); tick();
        chk("rst_arvalid", m_arvalid, 0);
        chk("rst_arready", s_arready, 0);
        chk("rst_idle", idle, 1);
        chk("rst_err", err, 0);
        rstn = 1'b1;

        // single read on port 0
        m_arready = 1'b1;
        s_arvalid = 2'b01; s_araddr[31:0] = 32'h100; s_arid[15:0] = 16'h0003;
        #1 chk("t2_arready", s_arready, 2'b01);
        tick();
        s_arvalid = '0;
        #1;
        chk("t2_arvalid", m_arvalid, 1);
        chk("t2_araddr", m_araddr, 32'h100);
        chk("t2_arid", m_arid, 16'h0003);
        tick();
        chk("t2_arvalid_drop", m_arvalid, 0);
        chk("t2_busy", idle, 0);
        m_rvalid = 1'b1; m_rid = 16'h0003; m_rdata = {480'h0, 32'hCAFE0003};
        s_rready = 2'b01;
        #1;
        chk("t2_rvalid", s_rvalid, 2'b01);
        chk("t2_rready", m_rready, 1);
        chk("t2_rdata", s_rdata[63:0], 64'hCAFE0003);
        chk("t2_rid", s_rid, 16'h0003);
        tick();
        m_rvalid = 1'b0;
        #1 chk("t2_idle", idle, 1);

        // fairness: pointer is at 1 after the port-0 grant
        g0 = 0; g1 = 0;
        s_arvalid = 2'b11;
        s_araddr = {32'h300, 32'h200};
        s_arid = {16'h0101, 16'h0001};
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("t3_gnt", s_arready, (i % 2 == 0) ? 2'b10 : 2'b01);
            if (s_arready[0]) g0++;
            if (s_arready[1]) g1++;
            tick();
            chk("t3_addr", m_araddr, (i % 2 == 0) ? 32'h300 : 32'h200);
        end
        chk("t3_cnt0", g0, 4);
        chk("t3_cnt1", g1, 4);
        s_arvalid = '0;
        tick();
        for (int i = 0; i < 4; i++) rbeat(16'h0001);
        for (int i = 0; i < 4; i++) rbeat(16'h0101);
        #1 chk("t3_idle", idle, 1);

        // backpressure
        m_arready = 1'b0;
        s_arvalid = 2'b01; s_araddr[31:0] = 32'h400; s_arid[15:0] = 16'h0011;
        #1 chk("t4_first", s_arready, 2'b01);
        tick();
        s_araddr[31:0] = 32'h500; s_arid[15:0] = 16'h0012;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t4_hold_rdy", s_arready, 0);
            chk("t4_hold_addr", m_araddr, 32'h400);
            chk("t4_hold_id", m_arid, 16'h0011);
            chk("t4_hold_vld", m_arvalid, 1);
            tick();
        end
        m_arready = 1'b1;
        #1 chk("t4_release", s_arready, 2'b01);
        tick();
        s_arvalid = '0;
        #1 chk("t4_second", m_araddr, 32'h500);
        tick();
        rbeat(16'h0011);
        rbeat(16'h0012);
        #1 chk("t4_idle", idle, 1);

        // credits: fill port 1
        g1 = 0;
        s_arvalid = 2'b10;
        for (int i = 0; i < 32; i++) begin
            s_arid[31:16] = 16'h0100 | 16'(i);
            s_araddr[63:32] = 32'h1000 + 32'(i * 64);
            #1;
            if (s_arready[1]) g1++;
            tick();
        end
        chk("t5_issued", g1, 32);
        s_arvalid = 2'b11;
        s_araddr[31:0] = 32'h800; s_arid[15:0] = 16'h0020;
        #1 chk("t5_block_a", s_arready, 2'b01);
        tick();
        m_rvalid = 1'b1; m_rid = 16'h0105; s_rready = 2'b10;
        #1;
        chk("t5_block_b", s_arready, 2'b01);
        chk("t5_rvalid", s_rvalid, 2'b10);
        chk("t5_rready", m_rready, 1);
        tick();
        m_rvalid = 1'b0;
        #1 chk("t5_regrant", s_arready, 2'b10);
        tick();
        s_arvalid = '0;
        tick();
        rbeat(16'h0020);
        rbeat(16'h0020);
        for (int i = 0; i < 32; i++) rbeat(16'h0100 | 16'(i));
        #1 chk("t5_idle", idle, 1);

        // errors
        m_rvalid = 1'b1; m_rid = 16'h0500; s_rready = 2'b00;
        #1;
        chk("t6_rready", m_rready, 1);
        chk("t6_rvalid", s_rvalid, 0);
        chk("t6_err_pre", err, 0);
        tick();
        m_rvalid = 1'b0;
        #1 chk("t6_err1", err, 2'b10);
        s_arvalid = 2'b01; s_araddr[31:0] = 32'h700; s_arid[15:0] = 16'h0107;
        #1 chk("t6_gnt", s_arready, 2'b01);
        tick();
        s_arvalid = '0;
        #1;
        chk("t6_fwd", m_arid, 16'h0107);
        chk("t6_err0", err, 2'b11);
        tick();
        rbeat(16'h0007);
        #1 chk("t6_idle", idle, 1);

        // reset mid-operation with a slot loaded
        m_arready = 1'b0;
        s_arvalid = 2'b01; s_araddr[31:0] = 32'h900; s_arid[15:0] = 16'h0030;
        tick();
        s_arvalid = '0;
        #1 chk("t7_loaded", m_arvalid, 1);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        #1;
        chk("t7_arvalid", m_arvalid, 0);
        chk("t7_idle", idle, 1);
        chk("t7_err", err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
